fpga_tx_scheduler: RTL and testbench

//   Shares one fpga_transmitter between NUM_REQ local requesters.

---
 rtl/fpga_link_pkg.sv | 15 +
 rtl/fpga_tx_scheduler_rr_arbiter.sv | 33 +++
 rtl/fpga_tx_scheduler.sv | 163 ++++++++++++++++
 tb/tb_fpga_tx_scheduler.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fpga_link_pkg.sv
// Shared FPGA-to-FPGA link definitions: controller state encoding and default byte width.
// Used by the transmit scheduler and by the link transmitter/receiver.
package fpga_link_pkg;

    localparam int LINK_DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT_HI,
        ST_WAIT_LO,
        ST_GAP
    } link_state_e;

endpackage

// File: rtl/fpga_tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first asserted request after rr_ptr,
// wrapping at NUM_REQ, so the most recent winner has the lowest priority.
module rr_arbiter
    import fpga_link_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int IDX_W = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] winner_oh,
    output logic [IDX_W-1:0]   winner_idx,
    output logic               any
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        winner_oh  = '0;
        winner_idx = '0;
        any        = 1'b0;
        cand       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!any && req[cand]) begin
                any             = 1'b1;
                winner_oh[cand] = 1'b1;
                winner_idx      = cand;
            end
        end
    end

endmodule

// File: rtl/fpga_tx_scheduler.sv
// Shares one link transmitter between NUM_REQ requesters: round-robin grant, byte latch,
// one start pulse per byte, busy tracking with timeout, and a per-requester done pulse.
module fpga_tx_scheduler
    import fpga_link_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int DATA_W         = LINK_DATA_W,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 4096,
    localparam int IDX_W = $clog2(NUM_REQ)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        grant,
    output logic [NUM_REQ-1:0]        done,
    output logic                      timeout_err,
    output logic [IDX_W-1:0]          err_id,
    output logic [DATA_W-1:0]         sent_data,
    output logic                      start,
    input  logic                      busy,
    output logic                      link_idle
);

    localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int GAP_W = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;

    link_state_e         state_q, state_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [NUM_REQ-1:0]  done_q, done_d;
    logic                tmo_err_q, tmo_err_d;
    logic [IDX_W-1:0]    err_id_q, err_id_d;
    logic [DATA_W-1:0]   sent_data_q, sent_data_d;
    logic                start_q, start_d;
    logic                link_idle_q, link_idle_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;

    logic [NUM_REQ-1:0]  arb_oh;
    logic [IDX_W-1:0]    arb_idx;
    logic                arb_any;
    logic [DATA_W-1:0]   arb_data;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req        (req),
        .rr_ptr     (rr_ptr_q),
        .winner_oh  (arb_oh),
        .winner_idx (arb_idx),
        .any        (arb_any)
    );

    always_comb begin
        arb_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_oh[i]) arb_data = req_data[i*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        done_d      = '0;
        tmo_err_d   = 1'b0;
        err_id_d    = err_id_q;
        sent_data_d = sent_data_q;
        start_d     = 1'b0;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        tmo_cnt_d   = tmo_cnt_q;
        gap_cnt_d   = gap_cnt_q;

        case (state_q)
            ST_IDLE: begin
                // A still-high busy means the previous byte is draining; hold off.
                if (arb_any && !busy) begin
                    grant_d     = arb_oh;
                    sent_data_d = arb_data;
                    rr_ptr_d    = arb_idx;
                    owner_d     = arb_idx;
                    state_d     = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                start_d   = 1'b1;
                tmo_cnt_d = '0;
                state_d   = ST_WAIT_HI;
            end
            ST_WAIT_HI, ST_WAIT_LO: begin
                // One counter spans both wait states; a normal exit wins over the timeout.
                tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                if (state_q == ST_WAIT_HI && busy) begin
                    state_d = ST_WAIT_LO;
                end else if (state_q == ST_WAIT_LO && !busy) begin
                    done_d    = grant_q;
                    grant_d   = '0;
                    gap_cnt_d = '0;
                    state_d   = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                end else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    tmo_err_d = 1'b1;
                    err_id_d  = owner_q;
                    grant_d   = '0;
                    gap_cnt_d = '0;
                    state_d   = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            default: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
        endcase

        link_idle_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            done_q      <= '0;
            tmo_err_q   <= 1'b0;
            err_id_q    <= '0;
            sent_data_q <= '0;
            start_q     <= 1'b0;
            link_idle_q <= 1'b1;
            rr_ptr_q    <= IDX_W'(NUM_REQ - 1);
            owner_q     <= '0;
            tmo_cnt_q   <= '0;
            gap_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            done_q      <= done_d;
            tmo_err_q   <= tmo_err_d;
            err_id_q    <= err_id_d;
            sent_data_q <= sent_data_d;
            start_q     <= start_d;
            link_idle_q <= link_idle_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            tmo_cnt_q   <= tmo_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
        end
    end

    assign grant       = grant_q;
    assign done        = done_q;
    assign timeout_err = tmo_err_q;
    assign err_id      = err_id_q;
    assign sent_data   = sent_data_q;
    assign start       = start_q;
    assign link_idle   = link_idle_q;

endmodule

// File: tb/tb_fpga_tx_scheduler.sv
// Directed bench for fpga_tx_scheduler with a behavioural transmitter/receiver stub
// (fixed busy length, captures sent_data on start) and a force-busy hook for timeouts.
module tb_fpga_tx_scheduler;

    localparam int NUM_REQ        = 4;
    localparam int DATA_W         = 8;
    localparam int GAP_CYCLES     = 2;
    localparam int TIMEOUT_CYCLES = 16;
    localparam int BUSY_LEN       = 3;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  grant, done;
    logic        timeout_err, start, link_idle, busy;
    logic [1:0]  err_id;
    logic [7:0]  sent_data;

    logic        force_busy = 1'b0;
    int          bcnt = 0;
    logic [7:0]  rxq[$];

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt[4];
    int tmo_seen, start_cnt, multi_grant, both_seen, done_mismatch;
    logic [3:0] prev_grant = '0;

    always #5 clock = ~clock;

    fpga_tx_scheduler #(
        .NUM_REQ(NUM_REQ), .DATA_W(DATA_W),
        .GAP_CYCLES(GAP_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clock(clock), .reset(reset), .req(req), .req_data(req_data),
        .grant(grant), .done(done), .timeout_err(timeout_err), .err_id(err_id),
        .sent_data(sent_data), .start(start), .busy(busy), .link_idle(link_idle)
    );

    // Transmitter/receiver stand-in: busy for BUSY_LEN cycles after each start.
    assign busy = (bcnt != 0) || force_busy;

    always @(posedge clock) begin
        if (reset) bcnt <= 0;
        else if (start) begin
            bcnt <= BUSY_LEN;
            rxq.push_back(sent_data);
        end else if (bcnt != 0) bcnt <= bcnt - 1;
    end

    // Event tallies over pre-edge values; the tests compare these against expectations.
    always @(posedge clock) begin
        for (int i = 0; i < 4; i++) if (done[i]) done_cnt[i]++;
        if (timeout_err) tmo_seen++;
        if (start) start_cnt++;
        if ($countones(grant) > 1) multi_grant++;
        if (done != 0 && timeout_err) both_seen++;
        if (done != 0 && done != prev_grant) done_mismatch++;
        prev_grant = grant;
    end

    task automatic clear_stats();
        foreach (done_cnt[i]) done_cnt[i] = 0;
        tmo_seen = 0; start_cnt = 0; multi_grant = 0; both_seen = 0; done_mismatch = 0;
        rxq.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1; req = '0; force_busy = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        clear_stats();
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clock);
        n_tests++; if (grant !== 4'b0) begin n_fail++; $display("FAIL reset_grant: got %b want 0000", grant); end
        n_tests++; if (done !== 4'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0000", done); end
        n_tests++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_tmo: got %b want 0", timeout_err); end
        n_tests++; if (err_id !== 2'd0) begin n_fail++; $display("FAIL reset_err_id: got %0d want 0", err_id); end
        n_tests++; if (sent_data !== 8'h00) begin n_fail++; $display("FAIL reset_sent_data: got %h want 00", sent_data); end
        n_tests++; if (start !== 1'b0) begin n_fail++; $display("FAIL reset_start: got %b want 0", start); end
        n_tests++; if (link_idle !== 1'b1) begin n_fail++; $display("FAIL reset_link_idle: got %b want 1", link_idle); end
        reset = 1'b0;
        clear_stats();
    endtask

    task automatic test_single();
        bit ok;
        do_reset();
        req_data[7:0] = 8'h01; req = 4'b0001;
        @(negedge clock);
        n_tests++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL single_grant_latency: got %b want 0001", grant); end
        n_tests++; if (start !== 1'b0) begin n_fail++; $display("FAIL single_start_early: got %b want 0", start); end
        @(negedge clock);
        n_tests++; if (start !== 1'b1) begin n_fail++; $display("FAIL single_start: got %b want 1", start); end
        @(negedge clock);
        n_tests++; if (start !== 1'b0) begin n_fail++; $display("FAIL single_start_width: got %b want 0", start); end
        ok = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            if (done != 0) begin ok = 1; break; end
        end
        n_tests++; if (!ok) begin n_fail++; $display("FAIL single_done_wait: none in 40 cycles, want done"); end
        n_tests++; if (done !== 4'b0001) begin n_fail++; $display("FAIL single_done: got %b want 0001", done); end
        req = '0;
        @(negedge clock);
        n_tests++; if (link_idle !== 1'b0) begin n_fail++; $display("FAIL single_gap_idle: got %b want 0", link_idle); end
        @(negedge clock);
        n_tests++; if (link_idle !== 1'b1) begin n_fail++; $display("FAIL single_link_idle: got %b want 1", link_idle); end
        repeat (4) @(negedge clock);
        n_tests++; if (start_cnt != 1) begin n_fail++; $display("FAIL single_start_count: got %0d want 1", start_cnt); end
        n_tests++; if (done_cnt[0] != 1) begin n_fail++; $display("FAIL single_done_count: got %0d want 1", done_cnt[0]); end
        n_tests++; if (rxq.size() != 1 || rxq[0] !== 8'h01) begin n_fail++; $display("FAIL single_rx: got %0d bytes first %h want 1 byte 01", rxq.size(), (rxq.size() > 0) ? rxq[0] : 8'hxx); end
    endtask

    task automatic test_round_robin();
        bit ok;
        logic [7:0] exp_rr [5] = '{8'h11, 8'h22, 8'h44, 8'h88, 8'h11};
        do_reset();
        req_data = 32'h88442211; req = 4'hF;
        ok = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clock);
            if (done_cnt[0] + done_cnt[1] + done_cnt[2] + done_cnt[3] >= 5) begin req = '0; ok = 1; break; end
        end
        n_tests++; if (!ok) begin n_fail++; $display("FAIL rr_wait: fewer than 5 done in 200 cycles"); end
        repeat (10) @(negedge clock);
        n_tests++; if (rxq.size() != 5) begin n_fail++; $display("FAIL rr_count: got %0d bytes want 5", rxq.size()); end
        for (int i = 0; i < 5 && i < rxq.size(); i++) begin
            n_tests++; if (rxq[i] !== exp_rr[i]) begin n_fail++; $display("FAIL rr_order[%0d]: got %h want %h", i, rxq[i], exp_rr[i]); end
        end
        n_tests++; if (done_cnt[0] != 2 || done_cnt[1] != 1 || done_cnt[2] != 1 || done_cnt[3] != 1) begin
            n_fail++; $display("FAIL rr_done_counts: got %0d/%0d/%0d/%0d want 2/1/1/1", done_cnt[0], done_cnt[1], done_cnt[2], done_cnt[3]); end
        n_tests++; if (multi_grant != 0) begin n_fail++; $display("FAIL rr_onehot: got %0d multi-grant cycles want 0", multi_grant); end
        n_tests++; if (done_mismatch != 0) begin n_fail++; $display("FAIL rr_done_owner: got %0d mismatches want 0", done_mismatch); end
    endtask

    task automatic test_data_stability();
        bit ok;
        do_reset();
        req_data[15:8] = 8'h55; req = 4'b0010;
        ok = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (busy) begin ok = 1; break; end
        end
        n_tests++; if (!ok) begin n_fail++; $display("FAIL stab_busy_wait: busy never rose"); end
        @(negedge clock);
        req_data[15:8] = 8'hAA;
        @(negedge clock);
        n_tests++; if (sent_data !== 8'h55) begin n_fail++; $display("FAIL stab_sent_wait_lo: got %h want 55", sent_data); end
        ok = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            if (done != 0) begin ok = 1; break; end
        end
        req = '0;
        n_tests++; if (!ok || done !== 4'b0010) begin n_fail++; $display("FAIL stab_done: got %b want 0010", done); end
        repeat (5) @(negedge clock);
        n_tests++; if (sent_data !== 8'h55) begin n_fail++; $display("FAIL stab_sent_after: got %h want 55", sent_data); end
        n_tests++; if (rxq.size() != 1 || rxq[0] !== 8'h55) begin n_fail++; $display("FAIL stab_rx: got %0d bytes first %h want 1 byte 55", rxq.size(), (rxq.size() > 0) ? rxq[0] : 8'hxx); end
    endtask

    task automatic test_timeout();
        int t;
        bit ok;
        do_reset();
        req_data[7:0] = 8'h10; req_data[23:16] = 8'h30; req = 4'b0101;
        @(negedge clock);
        force_busy = 1'b1;
        @(negedge clock);
        n_tests++; if (start !== 1'b1) begin n_fail++; $display("FAIL tmo_start: got %b want 1", start); end
        t = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clock);
            if (timeout_err) begin t = c; break; end
        end
        n_tests++; if (t != TIMEOUT_CYCLES) begin n_fail++; $display("FAIL tmo_latency: got %0d cycles want %0d", t, TIMEOUT_CYCLES); end
        n_tests++; if (err_id !== 2'd0) begin n_fail++; $display("FAIL tmo_err_id: got %0d want 0", err_id); end
        n_tests++; if (done !== 4'b0 || grant !== 4'b0) begin n_fail++; $display("FAIL tmo_done_grant: got done %b grant %b want 0000/0000", done, grant); end
        req = 4'b0100; force_busy = 1'b0;
        ok = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            if (done != 0) begin ok = 1; break; end
        end
        req = '0;
        n_tests++; if (!ok || done !== 4'b0100) begin n_fail++; $display("FAIL tmo_next_done: got %b want 0100", done); end
        repeat (4) @(negedge clock);
        n_tests++; if (done_cnt[0] != 0 || tmo_seen != 1 || both_seen != 0) begin
            n_fail++; $display("FAIL tmo_counts: got done0=%0d tmo=%0d both=%0d want 0/1/0", done_cnt[0], tmo_seen, both_seen); end
        n_tests++; if (rxq.size() != 2 || rxq[rxq.size()-1] !== 8'h30) begin n_fail++; $display("FAIL tmo_rx: got %0d bytes want 2 ending 30", rxq.size()); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        do_reset();
        req_data[23:16] = 8'h77; req = 4'b0100;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (busy) break;
        end
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        n_tests++; if (grant !== 4'b0 || done !== 4'b0 || start !== 1'b0 || timeout_err !== 1'b0) begin
            n_fail++; $display("FAIL midrst_ctrl: got grant %b done %b start %b tmo %b want all 0", grant, done, start, timeout_err); end
        n_tests++; if (sent_data !== 8'h00 || err_id !== 2'd0 || link_idle !== 1'b1) begin
            n_fail++; $display("FAIL midrst_out: got data %h err_id %0d idle %b want 00/0/1", sent_data, err_id, link_idle); end
        reset = 1'b0; req = 4'b0101; req_data[7:0] = 8'h5A;
        @(negedge clock);
        n_tests++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL midrst_first: got %b want 0001", grant); end
        ok = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            if (done != 0) begin ok = 1; break; end
        end
        req = '0;
        n_tests++; if (!ok || done !== 4'b0001) begin n_fail++; $display("FAIL midrst_done: got %b want 0001", done); end
        repeat (6) @(negedge clock);
        n_tests++; if (done_cnt[2] != 0 || done_cnt[0] != 1) begin n_fail++; $display("FAIL midrst_counts: got done2=%0d done0=%0d want 0/1", done_cnt[2], done_cnt[0]); end
    endtask

    task automatic test_drop_req();
        bit ok;
        do_reset();
        req_data[23:16] = 8'hFF; req = 4'b0100;
        @(negedge clock);
        n_tests++; if (grant !== 4'b0100) begin n_fail++; $display("FAIL drop_grant: got %b want 0100", grant); end
        req = '0;
        ok = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clock);
            if (done != 0) begin ok = 1; break; end
        end
        n_tests++; if (!ok || done !== 4'b0100) begin n_fail++; $display("FAIL drop_done: got %b want 0100", done); end
        repeat (10) @(negedge clock);
        n_tests++; if (start_cnt != 1 || done_cnt[2] != 1) begin n_fail++; $display("FAIL drop_counts: got starts=%0d done2=%0d want 1/1", start_cnt, done_cnt[2]); end
        n_tests++; if (rxq.size() != 1 || rxq[0] !== 8'hFF) begin n_fail++; $display("FAIL drop_rx: got %0d bytes first %h want 1 byte FF", rxq.size(), (rxq.size() > 0) ? rxq[0] : 8'hxx); end
    endtask

    initial begin
        clear_stats();
        test_reset();
        test_single();
        test_round_robin();
        test_data_stability();
        test_timeout();
        test_reset_mid();
        test_drop_req();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
